// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the 5-stage MIPS pipeline.
//
// Takes the MEM/WB pipeline-register outputs, picks the write-back value and
// owns the 32x32 register file. The ID stage reads that file through two
// combinational ports that return same-cycle write-back data first. The block
// decodes syscalls for halt and display, and keeps retire and cycle counters.
//
// Ports:
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   Eff                   slot in WB holds a real instruction
//   Instr, PC             instruction word and its address
//   PC_plus_four          JAL link value
//   AluResult, MemData    ALU result and data-memory read data
//   JAL, MemToReg         write-back source select (JAL has priority)
//   RegWrite, WAdr        register write request and destination
//   R1Adr/R1, R2Adr/R2    ID-stage read ports
//   WData, WE, WAdr_Out   write-back bus, exported for forwarding
//   Halt                  sticky halt, set by the halting syscall
//   Display               last $a0 value latched by the display syscall
//   RetireCount           retired effective instructions
//   CycleCount            cycles spent running
//   LastPC                PC of the last retired instruction
module wb_stage #(
  parameter int HALT_CODE = 10,
  parameter int DISP_CODE = 34,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Eff,
  input  logic [31:0]      Instr,
  input  logic [31:0]      PC,
  input  logic [31:0]      PC_plus_four,
  input  logic [31:0]      AluResult,
  input  logic [31:0]      MemData,
  input  logic             JAL,
  input  logic             MemToReg,
  input  logic             RegWrite,
  input  logic [4:0]       WAdr,
  input  logic [4:0]       R1Adr,
  input  logic [4:0]       R2Adr,
  output logic [31:0]      R1,
  output logic [31:0]      R2,
  output logic [31:0]      WData,
  output logic             WE,
  output logic [4:0]       WAdr_Out,
  output logic             Halt,
  output logic [31:0]      Display,
  output logic [CNT_W-1:0] RetireCount,
  output logic [CNT_W-1:0] CycleCount,
  output logic [31:0]      LastPC
);

  localparam logic [31:0]      HALT_V  = 32'(HALT_CODE);
  localparam logic [31:0]      DISP_V  = 32'(DISP_CODE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] regs [32];
  logic        run;
  logic        sys;
  logic [31:0] v0, a0;

  // Only the opcode and funct fields matter for syscall decode.
  logic unused_instr;
  assign unused_instr = ^Instr[25:6];

  assign run      = (state == ST_RUN);
  assign WAdr_Out = WAdr;
  assign Halt     = (state == ST_HALT);

  always_comb begin
    WData = AluResult;
    if (JAL)
      WData = PC_plus_four;
    else if (MemToReg)
      WData = MemData;
  end

  assign WE = Eff & RegWrite & (WAdr != 5'd0) & run;

  // Write-first read ports: a register being written this cycle is returned
  // from the write-back bus, so ID never sees a stale value.
  always_comb begin
    R1 = regs[R1Adr];
    if (R1Adr == 5'd0)
      R1 = '0;
    else if (WE && (R1Adr == WAdr))
      R1 = WData;
  end

  always_comb begin
    R2 = regs[R2Adr];
    if (R2Adr == 5'd0)
      R2 = '0;
    else if (WE && (R2Adr == WAdr))
      R2 = WData;
  end

  // A syscall never writes a register, so $v0/$a0 come straight from the array.
  assign sys = Eff & (Instr[31:26] == 6'd0) & (Instr[5:0] == 6'h0C);
  assign v0  = regs[2];
  assign a0  = regs[4];

  always_comb begin
    state_nxt = state;
    if (run && sys && (v0 == HALT_V))
      state_nxt = ST_HALT;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  // Register file: WE already excludes $0 and the halted state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (WE) begin
      regs[WAdr] <= WData;
    end
  end

  // Statistics and display freeze once halted; the edge that enters HALT
  // still counts as a run cycle and retires the halting syscall.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Display     <= '0;
      RetireCount <= '0;
      CycleCount  <= '0;
      LastPC      <= '0;
    end else if (run) begin
      CycleCount <= CycleCount + CNT_ONE;
      if (Eff) begin
        RetireCount <= RetireCount + CNT_ONE;
        LastPC      <= PC;
      end
      if (sys && (v0 == DISP_V))
        Display <= a0;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage. The stimulus process sets inputs just after a
// rising edge and queues the values it expects in that cycle; a monitor on the
// falling edge pops every entry tagged with the current cycle and compares.
module tb_wb_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        Eff;
  logic [31:0] Instr, PC, PC_plus_four, AluResult, MemData;
  logic        JAL, MemToReg, RegWrite;
  logic [4:0]  WAdr, R1Adr, R2Adr;
  logic [31:0] R1, R2, WData;
  logic        WE;
  logic [4:0]  WAdr_Out;
  logic        Halt;
  logic [31:0] Display;
  logic [31:0] RetireCount, CycleCount;
  logic [31:0] LastPC;

  wb_stage #(.HALT_CODE(10), .DISP_CODE(34), .CNT_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .Eff(Eff), .Instr(Instr), .PC(PC),
    .PC_plus_four(PC_plus_four), .AluResult(AluResult), .MemData(MemData),
    .JAL(JAL), .MemToReg(MemToReg), .RegWrite(RegWrite), .WAdr(WAdr),
    .R1Adr(R1Adr), .R2Adr(R2Adr), .R1(R1), .R2(R2), .WData(WData), .WE(WE),
    .WAdr_Out(WAdr_Out), .Halt(Halt), .Display(Display),
    .RetireCount(RetireCount), .CycleCount(CycleCount), .LastPC(LastPC)
  );

  always #5 CLK = ~CLK;

  localparam int S_R1 = 0, S_R2 = 1, S_WDATA = 2, S_WE = 3, S_HALT = 4,
                 S_DISP = 5, S_RET = 6, S_CYC = 7, S_LPC = 8, S_WADRO = 9;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t q[$];
  exp_t keep[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] pick(int s);
    case (s)
      S_R1:    return R1;
      S_R2:    return R2;
      S_WDATA: return WData;
      S_WE:    return {31'd0, WE};
      S_HALT:  return {31'd0, Halt};
      S_DISP:  return Display;
      S_RET:   return RetireCount;
      S_CYC:   return CycleCount;
      S_LPC:   return LastPC;
      default: return {27'd0, WAdr_Out};
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle.
  always @(negedge CLK) begin
    logic [31:0] got;
    keep = {};
    foreach (q[i]) begin
      if (q[i].cyc == cyc) begin
        got = pick(q[i].sig);
        total++;
        if (got !== q[i].val) begin
          bad++;
          $display("FAIL %s @cyc %0d: got 0x%08h, want 0x%08h",
                   q[i].nm, cyc, got, q[i].val);
        end
      end else begin
        keep.push_back(q[i]);
      end
    end
    q = keep;
  end

  task automatic chk(int s, logic [31:0] v, string nm);
    exp_t e;
    e.cyc = cyc;
    e.sig = s;
    e.val = v;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Eff = 0; Instr = 0; PC = 0; PC_plus_four = 0; AluResult = 0; MemData = 0;
    JAL = 0; MemToReg = 0; RegWrite = 0; WAdr = 0;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d, logic [31:0] pc);
    idle();
    Eff = 1; RegWrite = 1; WAdr = a; AluResult = d; PC = pc;
  endtask

  task automatic syscall(logic [31:0] pc);
    idle();
    Eff = 1; Instr = 32'h0000_000C; PC = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    R1Adr = 0; R2Adr = 0;
    RST_N = 0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1;

    // r=0..31: every register reads 0 after reset
    chk(S_HALT, 0, "reset_halt");
    chk(S_DISP, 0, "reset_display");
    chk(S_RET,  0, "reset_retire");
    chk(S_CYC,  0, "reset_cycle");
    chk(S_LPC,  0, "reset_lastpc");
    for (int i = 0; i < 32; i++) begin
      if (i > 0) nxt();
      R1Adr = 5'(i); R2Adr = 5'(31 - i);
      chk(S_R1, 0, "reset_r1");
      chk(S_R2, 0, "reset_r2");
    end

    // r=32: write reg8 = 0x1234
    nxt(); wr(8, 32'h1234, 32'h100); R1Adr = 8; R2Adr = 0;
    chk(S_WDATA, 32'h1234, "wdata_alu");
    chk(S_WE, 1, "we_write");
    chk(S_WADRO, 8, "wadr_out");
    chk(S_CYC, 32, "cycle_r32");

    // r=33: bypass of MemData into R1, reg8 from the array on R2
    nxt(); wr(9, 32'h1111, 32'h104); MemToReg = 1; MemData = 32'hDEADBEEF;
    R1Adr = 9; R2Adr = 8;
    chk(S_R1, 32'hDEADBEEF, "bypass_r1");
    chk(S_R2, 32'h1234, "regfile_r8");
    chk(S_WDATA, 32'hDEADBEEF, "wdata_mem");
    chk(S_RET, 1, "retire_one");
    chk(S_LPC, 32'h100, "lastpc_first");

    // r=34: write to $0 retires but does not write
    nxt(); wr(0, 32'hFFFF, 32'h108); R1Adr = 0; R2Adr = 9;
    chk(S_WE, 0, "we_r0");
    chk(S_R1, 0, "r0_reads_zero");
    chk(S_R2, 32'hDEADBEEF, "regfile_r9");
    chk(S_RET, 2, "retire_two");

    // r=35: JAL beats MemToReg
    nxt(); wr(31, 32'hBBBB, 32'h3000); JAL = 1; MemToReg = 1;
    MemData = 32'hAAAA; PC_plus_four = 32'h3004; R1Adr = 0; R2Adr = 0;
    chk(S_WDATA, 32'h3004, "wdata_jal");
    chk(S_RET, 3, "retire_r0_counted");

    // r=36..38: bubbles with RegWrite set
    for (int i = 0; i < 3; i++) begin
      nxt(); idle(); RegWrite = 1; WAdr = 5; AluResult = 32'h5555;
      R1Adr = 31; R2Adr = 5;
      chk(S_WE, 0, "we_bubble");
      chk(S_R2, 0, "bubble_no_bypass");
    end

    // r=39: reg2 = 34; bubbles left reg5 and RetireCount alone
    nxt(); wr(2, 32'd34, 32'h200); R1Adr = 31; R2Adr = 5;
    chk(S_R1, 32'h3004, "reg31_link");
    chk(S_R2, 0, "reg5_unchanged");
    chk(S_RET, 4, "retire_after_bubbles");
    chk(S_CYC, 39, "cycle_after_bubbles");
    chk(S_LPC, 32'h3000, "lastpc_jal");

    // r=40: reg4 = 0x55
    nxt(); wr(4, 32'h55, 32'h204);
    chk(S_RET, 5, "retire_five");

    // r=41: display syscall
    nxt(); syscall(32'h208);
    chk(S_DISP, 0, "display_before");
    chk(S_RET, 6, "retire_six");

    // r=42: display latched; reg2 = 10
    nxt(); wr(2, 32'd10, 32'h20C);
    chk(S_DISP, 32'h55, "display_a0");
    chk(S_HALT, 0, "no_halt_on_disp");
    chk(S_LPC, 32'h208, "lastpc_syscall");

    // r=43: halting syscall
    nxt(); syscall(32'h210);
    chk(S_HALT, 0, "halt_not_yet");
    chk(S_RET, 8, "retire_eight");

    // r=44: halted; write attempt ignored
    nxt(); wr(7, 32'h7777, 32'h214); R1Adr = 7;
    chk(S_HALT, 1, "halt_set");
    chk(S_WE, 0, "we_halted");
    chk(S_R1, 0, "no_bypass_halted");
    chk(S_RET, 9, "retire_halt_counted");
    chk(S_CYC, 44, "cycle_halt_edge");
    chk(S_LPC, 32'h210, "lastpc_halt");

    // r=45: everything frozen
    nxt(); idle(); Eff = 1; PC = 32'h218; R1Adr = 7;
    chk(S_R1, 0, "reg7_unwritten");
    chk(S_HALT, 1, "halt_sticky");
    chk(S_RET, 9, "retire_frozen");
    chk(S_CYC, 44, "cycle_frozen");
    chk(S_LPC, 32'h210, "lastpc_frozen");
    chk(S_DISP, 32'h55, "display_held");

    // r=46: reset pulse between edges
    nxt(); idle(); R1Adr = 8; R2Adr = 4;
    RST_N = 0;
    #2;
    RST_N = 1;
    chk(S_HALT, 0, "async_halt");
    chk(S_RET, 0, "async_retire");
    chk(S_CYC, 0, "async_cycle");
    chk(S_DISP, 0, "async_display");
    chk(S_LPC, 0, "async_lastpc");
    chk(S_R1, 0, "async_reg8");
    chk(S_R2, 0, "async_reg4");

    // r=47..48: normal operation after release
    nxt(); wr(8, 32'hCAFE, 32'h300); R1Adr = 8;
    chk(S_R1, 32'hCAFE, "post_bypass");
    chk(S_WE, 1, "post_we");
    chk(S_CYC, 1, "post_cycle1");

    nxt(); idle(); R1Adr = 8;
    chk(S_R1, 32'hCAFE, "post_reg8");
    chk(S_RET, 1, "post_retire");
    chk(S_CYC, 2, "post_cycle2");
    chk(S_LPC, 32'h300, "post_lastpc");

    repeat (3) nxt();
    if (q.size() != 0) begin
      $display("FAIL pending: got %0d unchecked, want 0", q.size());
      bad += q.size();
      total += q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
